// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter merging NREQ producers into one synchronous FIFO write port.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic [NREQ-1:0]          reqValid,
   input  logic [NREQ*WIDTH-1:0]    reqData,
   output logic [NREQ-1:0]          reqReady,
   input  logic                     fifoFull,
   output logic                     fifoWrEn,
   output logic [WIDTH-1:0]         fifoDataIn,
   output logic [$clog2(NREQ)-1:0]  grantId,
   output logic                     busy
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_BURST) + 1;
   typedef enum logic {IDLE, BURST} state_t;
   state_t state;
   logic [IW-1:0] owner, rrPtr, winner, sel;
   logic [CW-1:0] beatCnt;
   logic [IW:0] idx;
   logic found, selValid, accept, atMax;

   function automatic logic [IW-1:0] nextIdx(input logic [IW-1:0] x);
      return (x == IW'(NREQ - 1)) ? '0 : x + 1'b1;
   endfunction

   // Scan downward so the lowest offset from rrPtr is the last, winning, assignment.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = {1'b0, rrPtr} + (IW+1)'(k);
         if (idx >= (IW+1)'(NREQ)) idx = idx - (IW+1)'(NREQ);
         if (reqValid[idx[IW-1:0]]) begin
            winner = idx[IW-1:0];
            found  = 1'b1;
         end
      end
   end

   assign busy     = (state == BURST);
   assign atMax    = (beatCnt == CW'(MAX_BURST));
   assign sel      = busy ? owner : winner;
   assign selValid = busy ? (reqValid[owner] && !atMax) : found;
   // Reset gates the combinational outputs so nothing leaks while rstN is low.
   assign accept     = rstN && selValid && !fifoFull;
   assign fifoWrEn   = accept;
   assign reqReady   = accept ? (NREQ'(1) << sel) : '0;
   assign fifoDataIn = (rstN && selValid) ? reqData[int'(sel)*WIDTH +: WIDTH] : '0;
   assign grantId    = (!busy && accept) ? winner : owner;

   // A full burst releases one cycle after its last beat, giving the bubble between owners.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state   <= IDLE;
         owner   <= '0;
         rrPtr   <= '0;
         beatCnt <= '0;
      end else if (!busy) begin
         if (accept) begin
            owner <= winner;
            if (MAX_BURST == 1) rrPtr <= nextIdx(winner);
            else begin
               beatCnt <= CW'(1);
               state   <= BURST;
            end
         end
      end else if (!reqValid[owner] || atMax) begin
         state   <= IDLE;
         rrPtr   <= nextIdx(owner);
         beatCnt <= '0;
      end else if (!fifoFull) begin
         beatCnt <= beatCnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench for fifo_wr_arbiter with a depth-8 FIFO model.
module tb_fifo_wr_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   typedef struct {logic [1:0] id; logic [W-1:0] data;} exp_t;

   logic clk = 1'b0, rstN = 1'b0;
   logic [N-1:0] reqValid = '0, reqReady;
   logic [N*W-1:0] reqData;
   logic fifoFull, fifoWrEn, busy;
   logic [W-1:0] fifoDataIn;
   logic [1:0] grantId;
   logic fullDrv = 1'b0, useFifo = 1'b0;
   int fifoCnt = 0, checks = 0, errors = 0, writes = 0;
   int beatNo[N], expBeat[N];
   exp_t sbq[$];
   logic [W-1:0] fq[$], orderQ[$];

   fifo_wr_arbiter #(.NREQ(N), .WIDTH(W), .MAX_BURST(4)) dut (
      .clk(clk), .rstN(rstN), .reqValid(reqValid), .reqData(reqData), .reqReady(reqReady),
      .fifoFull(fifoFull), .fifoWrEn(fifoWrEn), .fifoDataIn(fifoDataIn), .grantId(grantId), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] wordOf(input int i, input int n);
      return 32'h50 + (32'(i) << 8) + (32'(n) << 16);
   endfunction

   assign fifoFull = useFifo ? (fifoCnt >= 8) : fullDrv;
   always_comb for (int i = 0; i < N; i++) reqData[i*W +: W] = wordOf(i, beatNo[i]);

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expPush(input int id);
      exp_t e;
      e.id = 2'(id);
      e.data = wordOf(id, expBeat[id]);
      expBeat[id]++;
      sbq.push_back(e);
      orderQ.push_back(e.data);
   endtask

   task automatic resetDut();
      rstN = 1'b0;
      reqValid = '0;
      tick();
      rstN = 1'b1;
   endtask

   // Monitor: compares every write against the scoreboard, then plays producer and FIFO.
   initial begin : mon
      exp_t e;
      logic pend;
      int pid;
      logic [W-1:0] pdata;
      forever begin
         @(negedge clk);
         pend = 1'b0;
         if (fifoWrEn) begin
            writes++;
            pend = 1'b1;
            pid = int'(grantId);
            pdata = fifoDataIn;
            chk("wrWhileFull", W'(fifoFull), '0);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpectedWrite: got id %0d data %h, expected no write", grantId, fifoDataIn);
            end else begin
               e = sbq.pop_front();
               chk("grantId", W'(grantId), W'(e.id));
               chk("dataIn", fifoDataIn, e.data);
               chk("reqReady", W'(reqReady), W'(4'b0001 << e.id));
            end
         end
         @(posedge clk);
         #1;
         if (pend) begin
            beatNo[pid]++;
            if (useFifo) begin
               fq.push_back(pdata);
               fifoCnt++;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not end within time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [24:0] pat, expPat;
      int w0;
      // reset holds every output low even with all producers requesting
      reqValid = 4'b1111;
      @(negedge clk);
      chk("rstWrEn", W'(fifoWrEn), '0);
      chk("rstReady", W'(reqReady), '0);
      chk("rstData", fifoDataIn, '0);
      chk("rstGrant", W'(grantId), '0);
      chk("rstBusy", W'(busy), '0);
      tick();
      reqValid = '0;
      rstN = 1'b1;
      // zero-latency first grant
      reqValid = 4'b0001;
      expPush(0);
      @(negedge clk);
      chk("t1WrEn", W'(fifoWrEn), W'(1));
      chk("t1Data", fifoDataIn, 32'h50);
      chk("t1Ready", W'(reqReady), W'(4'b0001));
      chk("t1BusyPre", W'(busy), '0);
      tick();
      reqValid = '0;
      @(negedge clk);
      chk("t1Busy", W'(busy), W'(1));
      tick();
      chk("t1Drained", W'(sbq.size()), '0);
      // all producers valid: 0,1,2,3,0 in four-beat bursts with a bubble after each
      resetDut();
      reqValid = 4'b1111;
      foreach (expPat[c]) expPat[c] = (c % 5 != 4);
      for (int b = 0; b < 5; b++) repeat (4) expPush(b % 4);
      w0 = writes;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         pat[c] = fifoWrEn;
         tick();
      end
      reqValid = '0;
      chk("t2Pattern", W'(pat), W'(expPat));
      chk("t2Writes", W'(writes - w0), W'(20));
      tick();
      chk("t2Drained", W'(sbq.size()), '0);
      // FIFO full mid-burst of producer 2
      resetDut();
      reqValid = 4'b0100;
      repeat (4) expPush(2);
      tick();
      tick();
      fullDrv = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t3HoldWrEn", W'(fifoWrEn), '0);
         chk("t3HoldGrant", W'(grantId), W'(2));
         chk("t3HoldBusy", W'(busy), W'(1));
         tick();
      end
      fullDrv = 1'b0;
      @(negedge clk);
      chk("t3Beat3", W'(fifoWrEn), W'(1));
      tick();
      @(negedge clk);
      chk("t3Beat4", W'(fifoWrEn), W'(1));
      tick();
      @(negedge clk);
      chk("t3Release", W'(fifoWrEn), '0);
      reqValid = '0;
      tick();
      chk("t3Drained", W'(sbq.size()), '0);
      // owner 1 drops early, producer 3 takes over from rrPtr 2
      resetDut();
      reqValid = 4'b1010;
      repeat (2) expPush(1);
      tick();
      tick();
      reqValid = 4'b1000;
      @(negedge clk);
      chk("t4RelWrEn", W'(fifoWrEn), '0);
      chk("t4RelBusy", W'(busy), W'(1));
      tick();
      expPush(3);
      @(negedge clk);
      chk("t4Grant", W'(grantId), W'(3));
      chk("t4WrEn", W'(fifoWrEn), W'(1));
      chk("t4RrPtr", W'(dut.rrPtr), W'(2));
      reqValid = '0;
      tick();
      tick();
      chk("t4Drained", W'(sbq.size()), '0);
      // reset during beat 3 of producer 1
      resetDut();
      reqValid = 4'b0010;
      repeat (2) expPush(1);
      tick();
      tick();
      rstN = 1'b0;
      @(negedge clk);
      chk("t5RstWrEn", W'(fifoWrEn), '0);
      chk("t5RstReady", W'(reqReady), '0);
      chk("t5RstData", fifoDataIn, '0);
      chk("t5RstGrant", W'(grantId), '0);
      chk("t5RstBusy", W'(busy), '0);
      tick();
      rstN = 1'b1;
      reqValid = 4'b1010;
      expPush(1);
      @(negedge clk);
      chk("t5Grant", W'(grantId), W'(1));
      reqValid = '0;
      tick();
      tick();
      chk("t5Drained", W'(sbq.size()), '0);
      // depth-8 FIFO: sixteen offered words, eight writes before full
      resetDut();
      fq.delete();
      orderQ.delete();
      fifoCnt = 0;
      useFifo = 1'b1;
      reqValid = 4'b1111;
      repeat (4) expPush(0);
      repeat (4) expPush(1);
      w0 = writes;
      repeat (20) tick();
      chk("t6Writes", W'(writes - w0), W'(8));
      chk("t6Full", W'(fifoFull), W'(1));
      reqValid = '0;
      tick();
      chk("t6Depth", W'(fq.size()), W'(8));
      for (int i = 0; i < 8; i++) chk("t6Order", fq[i], orderQ[i]);
      useFifo = 1'b0;
      fifoCnt = 0;
      chk("t6Drained", W'(sbq.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of producers (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 32, giving the data word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum consecutive beats per grant (1..16).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The block SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port reqValid, input, NREQ bits: producer i has a word pending.
REQ-007 The block SHALL have port reqData, input, NREQ*WIDTH bits: producer i's word occupies bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port reqReady, output, NREQ bits: one-hot, marking the word of producer i as consumed this cycle.
REQ-009 The block SHALL have port fifoFull, input, 1 bit: the full flag of the downstream synchronous FIFO.
REQ-010 The block SHALL have port fifoWrEn, output, 1 bit: the write enable of the downstream FIFO.
REQ-011 The block SHALL have port fifoDataIn, output, WIDTH bits: the write data of the downstream FIFO.
REQ-012 The block SHALL have port grantId, output, clog2(NREQ) bits: the current or last owner index.
REQ-013 The block SHALL have port busy, output, 1 bit: high while the state is BURST.

Function
REQ-014 The state machine SHALL have two states: IDLE (no owner) and BURST (owner held).
REQ-015 The registered state SHALL be: state, owner, rrPtr and beatCnt, where beatCnt is clog2(MAX_BURST)+1 bits wide.
REQ-016 In IDLE, the winner SHALL be the first i with reqValid[i]=1, searched from rrPtr upward with modulo-NREQ wrap.
REQ-017 In IDLE, a beat SHALL be accepted in the same cycle when a winner exists and fifoFull=0, giving zero-cycle arbitration latency.
REQ-018 On an IDLE accept: owner<=winner, beatCnt<=1, state<=BURST; if MAX_BURST=1, the block SHALL instead release immediately.
REQ-019 In IDLE with no valid request, or with fifoFull=1, no beat SHALL be accepted and the state SHALL be unchanged.
REQ-020 In BURST, a beat SHALL be accepted when reqValid[owner]=1 and fifoFull=0, and beatCnt SHALL then increment.
REQ-021 In BURST with reqValid[owner]=1 and fifoFull=1, the block SHALL hold with no accept, no count change and no release.
REQ-022 In BURST with reqValid[owner]=0, the block SHALL release without accepting.
REQ-023 In BURST, when an accepted beat brings beatCnt to MAX_BURST, the block SHALL release after that beat.
REQ-024 Release SHALL mean: state<=IDLE and rrPtr<=(owner+1) mod NREQ; the one bubble cycle before the next IDLE arbitration is required behaviour.
REQ-025 fifoWrEn SHALL be 1 exactly in cycles where a beat is accepted, and SHALL never be 1 while fifoFull=1.
REQ-026 reqReady[k] SHALL equal fifoWrEn when k is the winner (IDLE) or the owner (BURST), and 0 otherwise.
REQ-027 fifoDataIn SHALL be the reqData slice of the winner (IDLE) or the owner (BURST), and all zeros when no requester is selected.
REQ-028 grantId SHALL show the winner during an IDLE accept, and the owner register otherwise.
REQ-029 fifoWrEn, fifoDataIn and reqReady SHALL be combinational from registered state, reqValid and fifoFull; the block SHALL add no data-path register.
REQ-030 The block SHALL be fair: a continuously valid producer SHALL be granted within (NREQ-1)*(MAX_BURST+1)+1 cycles while fifoFull=0.

Reset
REQ-031 While rstN=0: state=IDLE, owner=0, rrPtr=0, beatCnt=0, and every output (reqReady, fifoWrEn, fifoDataIn, grantId, busy) SHALL be 0, regardless of the inputs.
REQ-032 Reset asserted mid-burst SHALL immediately drop fifoWrEn and discard the burst, and the first post-reset arbitration SHALL start from index 0.

Verification
REQ-033 Bench: reset; reqValid=4'b0001, reqData[0]=0x50, fifoFull=0 -> fifoWrEn=1, fifoDataIn=0x50 and reqReady=0001 in that same cycle, then busy=1.
REQ-034 Bench: all four producers valid for 25 cycles -> grants 0,1,2,3,0, four beats each, one bubble between bursts, 20 writes total.
REQ-035 Bench: owner 2 mid-burst (beatCnt=2), fifoFull=1 for 3 cycles -> fifoWrEn=0, grantId=2 and busy=1 throughout, then beats 3 and 4 complete after fifoFull falls.
REQ-036 Bench: owner 1 drops reqValid after 2 beats while producer 3 is valid -> release, bubble, then grantId=3 and rrPtr=2.
REQ-037 Bench: rstN pulsed low during beat 3 of producer 1 -> outputs 0 during reset; afterwards, with producers 1 and 3 valid, the next grant goes to producer 1, searched from index 0.
REQ-038 Bench: integrate with FIFO_Sync (DEPTH=8) -> sixteen offered words yield exactly eight writes before full, with no fifoWrEn while full, and readout order matching the grant order.
